// File: rtl/zmips_wb_ctrl.sv
// Writeback controller: merges single-cycle ALU results with FIFO-buffered mul/div
// results onto the register file write port, and tracks long-latency destinations.
module zmips_wb_ctrl #(
  parameter int MD_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rd_addr_0,
  input  logic [4:0]  rd_addr_1,
  output logic        busy_0,
  output logic        busy_1,
  output logic        md_pri,
  output logic        wr,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        err
);

  localparam int PW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int CW = $clog2(MD_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    md_addr_mem [MD_DEPTH];
  logic [31:0]   md_data_mem [MD_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pending_q, pending_d;
  logic          wr_q, wr_d;
  logic          from_md_q, from_md_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          err_q, err_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          clr_en;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic          issue_conflict;
  logic          alu_conflict;
  logic          pri_violation;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(MD_DEPTH));
  assign push       = md_valid && !fifo_full;
  assign pop        = !alu_valid && !fifo_empty;
  assign head_addr  = md_addr_mem[rd_ptr_q];
  assign head_data  = md_data_mem[rd_ptr_q];
  // A retiring mul/div write releases its destination at the end of the write cycle.
  assign clr_en     = wr_q && from_md_q;

  assign md_ready = !fifo_full;
  assign md_pri   = (starve_q >= SW'(STARVE_MAX));
  assign busy_0   = pending_q[rd_addr_0];
  assign busy_1   = pending_q[rd_addr_1];
  assign wr       = wr_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      md_addr_mem[wr_ptr_q] <= md_addr;
      md_data_mem[wr_ptr_q] <= md_data;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_d      = 1'b0;
    from_md_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    starve_d  = '0;
    pending_d = pending_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (alu_valid) begin
      wr_d      = (alu_addr != '0);
      wr_addr_d = alu_addr;
      wr_data_d = alu_data;
    end else if (pop) begin
      wr_d      = (head_addr != '0);
      from_md_d = 1'b1;
      wr_addr_d = head_addr;
      wr_data_d = head_data;
    end

    // Saturates so md_pri stays up until the head finally wins.
    if (!fifo_empty && alu_valid) begin
      starve_d = (starve_q >= SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end

    if (clr_en) begin
      pending_d[wr_addr_q] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  // A register being released on this same edge is no longer considered outstanding.
  always_comb begin
    issue_conflict = issue_valid && (issue_addr != '0) && pending_q[issue_addr] &&
                     !(clr_en && (wr_addr_q == issue_addr));
    alu_conflict   = alu_valid && (alu_addr != '0) && pending_q[alu_addr] &&
                     !(clr_en && (wr_addr_q == alu_addr));
    pri_violation  = alu_valid && md_pri;
    err_d          = err_q || issue_conflict || alu_conflict || pri_violation;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      wr_q      <= 1'b0;
      from_md_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      wr_q      <= wr_d;
      from_md_q <= from_md_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/zmips_wb_ctrl.md
Name: zmips_wb_ctrl

Overview:
Writeback controller that owns the register file's single write port (wr, wr_addr, wr_data). It merges single-cycle ALU results with results from the multi-cycle mul/div unit, buffering the latter in a small FIFO. It keeps a pending-register scoreboard so operand-fetch logic can stall reads of registers with outstanding long-latency writes. It sits between the execute stage and the register file.

Parameters:
MD_DEPTH, 4, mul/div result FIFO entries; power of two, >=2.
STARVE_MAX, 8, consecutive cycles a non-empty FIFO head may lose to the ALU before md_pri asserts; >=1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
alu_valid  in  1  ALU result present this cycle; no backpressure, always accepted.
alu_addr  in  5  ALU destination register.
alu_data  in  32  ALU result.
md_valid  in  1  mul/div result offered.
md_addr  in  5  mul/div destination register.
md_data  in  32  mul/div result.
md_ready  out  1  FIFO can accept; equals !full (combinational from state).
issue_valid  in  1  long-latency op issued this cycle.
issue_addr  in  5  destination register of the issued op.
rd_addr_0  in  5  operand-fetch read address 0.
rd_addr_1  in  5  operand-fetch read address 1.
busy_0  out  1  pending[rd_addr_0]; combinational.
busy_1  out  1  pending[rd_addr_1]; combinational.
md_pri  out  1  upstream must hold alu_valid low next cycle.
wr  out  1  register file write enable (registered).
wr_addr  out  5  register file write address (registered).
wr_data  out  32  register file write data (registered).
err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n=0): wr=0, wr_addr=0, wr_data=0, FIFO empty (md_ready=1), pending all 0, starve counter 0, md_pri=0, err=0. Reset mid-operation discards FIFO contents and pending bits. An in-flight write is dropped.
- FIFO push: on an edge where md_valid && md_ready. Pop: on an edge where the FIFO is non-empty and the head is selected. When full, a push and a pop in the same cycle are not allowed: md_ready=0 when full.
- Selection, cycle N: alu_valid -> the ALU result is selected. Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped. Otherwise nothing is selected.
- Output stage: the selection in cycle N is registered at the edge ending N. In cycle N+1, wr=1 with that addr/data, and the regfile commits it at the edge ending N+1. If nothing was selected, wr=0 in N+1.
- Register $0: any selected result with addr=0 produces wr=0. It still pops the FIFO.
- Latency: ALU result lands 1 cycle after it is presented. A mul/div result accepted at edge E appears on wr at the earliest in the cycle after E+1.
- Scoreboard: issue_valid && issue_addr!=0 sets pending[issue_addr] at the edge.
- Scoreboard clear: pending[a] clears at the edge ending the cycle in which wr=1, wr_addr=a, and the write originated from the FIFO. busy stays high until the data is in the regfile.
- Scoreboard conflicts: if a set and a clear of the same address occur on the same edge, the set wins. issue_valid to an address already pending sets err. An ALU write to a pending address sets err; the write still occurs.
- Starvation: the counter increments each cycle the FIFO is non-empty and alu_valid=1. It resets to 0 on any FIFO pop or when the FIFO is empty. md_pri = (count >= STARVE_MAX). When md_pri=1, the next cycle with alu_valid=0 pops the head. If alu_valid=1 while md_pri=1, err is set and the ALU still wins.
- err is sticky until reset.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 FIFO entries and pending[5]=1 -> immediately wr=0, md_ready=1, busy for reg 5 = 0, err=0.
- ALU path: alu_valid with addr=7, data=0xDEADBEEF in cycle N -> wr=1, wr_addr=7, wr_data=0xDEADBEEF in N+1 only. With addr=0 -> wr stays 0.
- Merge: issue reg 9, then md result (9, 0x1234) pushed while the ALU is active 2 cycles -> the ALU writes first. The md write follows in the first ALU-idle cycle+1. busy for reg 9 stays 1 until the edge ending that write cycle, then 0.
- Backpressure: push MD_DEPTH=4 md results with the ALU busy -> md_ready=0 after the 4th. With the ALU idle, the entries drain in FIFO order, one write per cycle.
- Starvation: FIFO non-empty, alu_valid held 8 cycles -> md_pri=1. Drop alu_valid -> head popped, md_pri=0. Repeat while keeping alu_valid=1 during md_pri -> err=1.
- Scoreboard conflict: on the same edge as the FIFO write retiring reg 3, issue a new op to reg 3 -> pending[3] remains 1, err=0. Issue to pending reg 4 -> err=1.
